// File: rtl/pc_unit_pkg.sv
// Shared encodings for the program-counter unit: next-PC select codes and
// the 2-bit control state encoding.
package pc_unit_pkg;

    // next-PC source select
    localparam logic [1:0] PC_SEL_SEQ = 2'b00;
    localparam logic [1:0] PC_SEL_BR  = 2'b01;
    localparam logic [1:0] PC_SEL_J   = 2'b10;
    localparam logic [1:0] PC_SEL_JR  = 2'b11;

    // control states
    localparam logic [1:0] ST_RUN  = 2'b00;
    localparam logic [1:0] ST_HALT = 2'b01;
    localparam logic [1:0] ST_TRAP = 2'b10;

endpackage : pc_unit_pkg

// File: rtl/pc_next_calc.sv
// Combinational next-PC generator: sequential, branch, jump and
// jump-register targets, plus a misalignment flag for jump-register.
module pc_next_calc
    import pc_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] pc,
    input  logic [1:0]       pc_sel,
    input  logic             branch_taken,
    input  logic [15:0]      branch_off,
    input  logic [25:0]      jump_index,
    input  logic [WIDTH-1:0] jr_target,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] next_pc,
    output logic             misaligned
);

    logic [WIDTH-1:0] br_off_ext;
    logic [WIDTH-1:0] br_target;
    logic [WIDTH-1:0] j_target;

    // All arithmetic wraps modulo 2^WIDTH by truncation.
    assign pc_plus4   = pc + WIDTH'(4);
    // Word offset: sign-extend imm16 and scale by 4.
    assign br_off_ext = {{(WIDTH-18){branch_off[15]}}, branch_off, 2'b00};
    assign br_target  = pc_plus4 + br_off_ext;
    // J-type keeps the upper region bits of pc+4.
    assign j_target   = {pc_plus4[WIDTH-1:28], jump_index, 2'b00};

    // Select the next PC; only a register target can be misaligned.
    always_comb begin
        next_pc    = pc_plus4;
        misaligned = 1'b0;
        case (pc_sel)
            PC_SEL_SEQ: next_pc = pc_plus4;
            PC_SEL_BR:  next_pc = branch_taken ? br_target : pc_plus4;
            PC_SEL_J:   next_pc = j_target;
            PC_SEL_JR: begin
                next_pc    = jr_target;
                misaligned = |jr_target[1:0];
            end
            default:    next_pc = pc_plus4;
        endcase
    end

endmodule : pc_next_calc

// File: rtl/pc_unit.sv
// Program-counter unit: PC register, RUN/HALT/TRAP control, exception PC
// capture and a counter of PC updates performed while running.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int          WIDTH        = 32,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h8000_0180,
    parameter int          CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       pc_sel,
    input  logic             branch_taken,
    input  logic [15:0]      branch_off,
    input  logic [25:0]      jump_index,
    input  logic [WIDTH-1:0] jr_target,
    input  logic             halt,
    input  logic             resume,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             pc_valid,
    output logic             trap,
    output logic [WIDTH-1:0] epc,
    output logic [CNT_W-1:0] upd_count
);

    localparam logic [WIDTH-1:0] RST_PC  = WIDTH'(RESET_VECTOR);
    localparam logic [WIDTH-1:0] TRAP_PC = WIDTH'(TRAP_VECTOR);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] next_pc;
    logic             misaligned;

    pc_next_calc #(
        .WIDTH (WIDTH)
    ) u_next (
        .pc           (pc_q),
        .pc_sel       (pc_sel),
        .branch_taken (branch_taken),
        .branch_off   (branch_off),
        .jump_index   (jump_index),
        .jr_target    (jr_target),
        .pc_plus4     (pc_plus4),
        .next_pc      (next_pc),
        .misaligned   (misaligned)
    );

    // Control FSM: in RUN, halt beats en; TRAP is a single-cycle detour.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (halt) begin
                    state_d = ST_HALT;
                end else if (en) begin
                    if (misaligned) begin
                        state_d = ST_TRAP;
                        pc_d    = TRAP_PC;
                        epc_d   = pc_q;
                    end else begin
                        pc_d  = next_pc;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_TRAP: state_d = ST_RUN;
            ST_HALT: begin
                // A still-asserted halt keeps us parked even with resume.
                if (resume && !halt) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // State registers; synchronous reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            pc_q    <= RST_PC;
            epc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc        = pc_q;
    assign epc       = epc_q;
    assign upd_count = cnt_q;
    assign pc_valid  = (state_q == ST_RUN);
    assign trap      = (state_q == ST_TRAP);

endmodule : pc_unit

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios followed by random stimulus. A
// driver updates an abstract reference model and queues the expected
// outputs for each clock edge; a monitor pops and compares after each edge.
module tb_pc_unit;

    localparam int          W    = 32;
    localparam int          CW   = 32;
    localparam logic [63:0] MASK = 64'hFFFF_FFFF;
    localparam logic [63:0] RV   = 64'h0000_0000;
    localparam logic [63:0] TV   = 64'h8000_0180;

    logic          clk = 1'b0;
    logic          rst, en, branch_taken, halt, resume;
    logic [1:0]    pc_sel;
    logic [15:0]   branch_off;
    logic [25:0]   jump_index;
    logic [W-1:0]  jr_target;
    logic [W-1:0]  pc, pc_plus4, epc;
    logic          pc_valid, trap;
    logic [CW-1:0] upd_count;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [W-1:0]  pc;
        logic [W-1:0]  pc4;
        logic [W-1:0]  epc;
        logic [CW-1:0] cnt;
        logic          valid;
        logic          trap;
    } exp_t;

    exp_t sb[$];

    // reference model: mode 0 running, 1 halted, 2 trapping
    int          m_mode;
    logic [63:0] m_pc, m_epc, m_cnt;

    pc_unit dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .pc_sel       (pc_sel),
        .branch_taken (branch_taken),
        .branch_off   (branch_off),
        .jump_index   (jump_index),
        .jr_target    (jr_target),
        .halt         (halt),
        .resume       (resume),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .pc_valid     (pc_valid),
        .trap         (trap),
        .epc          (epc),
        .upd_count    (upd_count)
    );

    always #5 clk = ~clk;

    // Apply one cycle of inputs, advance the model, queue what must appear.
    task automatic cyc(input logic r, input logic e, input logic [1:0] sel,
                       input logic tk, input logic [15:0] off,
                       input logic [25:0] idx, input logic [31:0] jt,
                       input logic h, input logic rs);
        logic [63:0] tgt;
        exp_t x;
        rst = r; en = e; pc_sel = sel; branch_taken = tk; branch_off = off;
        jump_index = idx; jr_target = jt; halt = h; resume = rs;
        if (r) begin
            m_mode = 0; m_pc = RV; m_epc = 0; m_cnt = 0;
        end else if (m_mode == 2) begin
            m_mode = 0;
        end else if (m_mode == 1) begin
            if (rs && !h) m_mode = 0;
        end else if (h) begin
            m_mode = 1;
        end else if (e) begin
            if (sel == 2'd3 && (jt % 4) != 0) begin
                m_mode = 2; m_epc = m_pc; m_pc = TV;
            end else begin
                case (sel)
                    2'd0: tgt = m_pc + 4;
                    2'd1: tgt = tk ? m_pc + 4 + 64'(longint'($signed(off)) * 4) : m_pc + 4;
                    2'd2: tgt = (((m_pc + 4) & MASK) / (64'd1 << 28)) * (64'd1 << 28) + 64'(idx) * 4;
                    default: tgt = 64'(jt);
                endcase
                m_pc  = tgt & MASK;
                m_cnt = (m_cnt + 1) & 64'hFFFF_FFFF;
            end
        end
        x.pc = m_pc[W-1:0];
        x.pc4 = W'((m_pc + 4) & MASK);
        x.epc = m_epc[W-1:0];
        x.cnt = m_cnt[CW-1:0];
        x.valid = (m_mode == 0);
        x.trap = (m_mode == 2);
        sb.push_back(x);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Shorthands
    task automatic seq_step(); cyc(0, 1, 2'd0, 0, 16'h0, 26'h0, 32'h0, 0, 0); endtask
    task automatic jr_step(input logic [31:0] t); cyc(0, 1, 2'd3, 0, 16'h0, 26'h0, t, 0, 0); endtask

    // Monitor: every edge must have a queued expectation that matches.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_pc",       64'(pc),        64'(e.pc));
                chk("sb_pc_plus4", 64'(pc_plus4),  64'(e.pc4));
                chk("sb_epc",      64'(epc),       64'(e.epc));
                chk("sb_count",    64'(upd_count), 64'(e.cnt));
                chk("sb_valid",    64'(pc_valid),  64'(e.valid));
                chk("sb_trap",     64'(trap),      64'(e.trap));
            end
        end
    end

    initial begin
        // 1: reset, then four sequential steps
        cyc(1, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0, 0, 0);
        chk("rst_pc", 64'(pc), 64'h0);
        chk("rst_valid", 64'(pc_valid), 64'd1);
        chk("rst_trap", 64'(trap), 64'd0);
        chk("rst_cnt", 64'(upd_count), 64'd0);
        repeat (4) seq_step();
        chk("seq_pc", 64'(pc), 64'h10);
        chk("seq_cnt", 64'(upd_count), 64'd4);

        // 2: branch taken backwards, then not taken
        jr_step(32'h100);
        cyc(0, 1, 2'd1, 1, 16'hFFFE, 26'h0, 32'h0, 0, 0);
        chk("br_taken", 64'(pc), 64'h0FC);
        jr_step(32'h100);
        cyc(0, 1, 2'd1, 0, 16'hFFFE, 26'h0, 32'h0, 0, 0);
        chk("br_not_taken", 64'(pc), 64'h104);

        // 3: jump keeps region bits, then aligned jr
        jr_step(32'h1000_0040);
        cyc(0, 1, 2'd2, 0, 16'h0, 26'h0000010, 32'h0, 0, 0);
        chk("jump", 64'(pc), 64'h1000_0040);
        jr_step(32'h2000);
        chk("jr", 64'(pc), 64'h2000);

        // 4: misaligned jr traps for exactly one cycle
        jr_step(32'h200);
        jr_step(32'h302);
        chk("trap_pulse", 64'(trap), 64'd1);
        chk("trap_pc", 64'(pc), 64'h8000_0180);
        chk("trap_epc", 64'(epc), 64'h200);
        chk("trap_valid", 64'(pc_valid), 64'd0);
        chk("trap_cnt", 64'(upd_count), 64'd12);
        jr_step(32'h303);
        chk("post_trap", 64'(trap), 64'd0);
        chk("post_trap_valid", 64'(pc_valid), 64'd1);
        chk("post_trap_pc", 64'(pc), 64'h8000_0180);

        // 5: halt beats en, halt+resume stays halted, resume runs again
        repeat (3) cyc(0, 1, 2'd0, 0, 16'h0, 26'h0, 32'h0, 1, 0);
        chk("halt_pc", 64'(pc), 64'h8000_0180);
        chk("halt_valid", 64'(pc_valid), 64'd0);
        cyc(0, 1, 2'd0, 0, 16'h0, 26'h0, 32'h0, 1, 1);
        chk("halt_resume_both", 64'(pc_valid), 64'd0);
        cyc(0, 1, 2'd0, 0, 16'h0, 26'h0, 32'h0, 0, 1);
        chk("resume_valid", 64'(pc_valid), 64'd1);
        chk("resume_pc", 64'(pc), 64'h8000_0180);
        seq_step();
        chk("resume_adv", 64'(pc), 64'h8000_0184);
        chk("resume_cnt", 64'(upd_count), 64'd13);

        // 6: stall, then reset out of HALT
        repeat (3) cyc(0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0, 0, 0);
        chk("stall_pc", 64'(pc), 64'h8000_0184);
        chk("stall_cnt", 64'(upd_count), 64'd13);
        cyc(0, 1, 2'd0, 0, 16'h0, 26'h0, 32'h0, 1, 0);
        cyc(1, 1, 2'd3, 0, 16'h0, 26'h0, 32'h303, 1, 0);
        chk("halt_rst_pc", 64'(pc), 64'h0);
        chk("halt_rst_cnt", 64'(upd_count), 64'd0);
        chk("halt_rst_valid", 64'(pc_valid), 64'd1);

        // random phase
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] t;
            t = $urandom;
            if ($urandom_range(3) != 0) t[1:0] = 2'b00;
            cyc(($urandom_range(63) == 0), ($urandom_range(3) != 0),
                2'($urandom_range(3)), 1'($urandom_range(1)),
                16'($urandom), 26'($urandom), t,
                ($urandom_range(9) == 0), ($urandom_range(2) == 0));
        end

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_pc_unit
